// File: rtl/reg_dump_pkg.sv
// -----------------------------------------------------------------------------
// reg_dump_pkg
// Shared types and default sizes for the register-file debug dumper.
//   state_t          : dump sequencer states
//   DEFAULT_NUM_REGS : number of registers walked (addresses 0..N-1)
//   DEFAULT_ADDR_W   : register-file address width
//   DEFAULT_DATA_W   : register data width
// -----------------------------------------------------------------------------
package reg_dump_pkg;

   localparam int DEFAULT_NUM_REGS = 32;
   localparam int DEFAULT_ADDR_W   = 5;
   localparam int DEFAULT_DATA_W   = 32;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_SEND  = 3'd2,
      ST_SUM   = 3'd3,
      ST_FIN   = 3'd4
   } state_t;

endpackage

// File: rtl/reg_dump.sv
// -----------------------------------------------------------------------------
// reg_dump
// Debug reader for the CPU register file. A start pulse walks addresses
// 0..NUM_REGS-1 through one registered read port, captures each word and
// streams it out on a valid/ready interface.
//
// Optional feature: define REG_DUMP_CHECKSUM_EN to append an XOR checksum of
// all dumped words as an extra word tagged out_idx = NUM_REGS.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   start     in   one-cycle dump request, honoured only when idle
//   busy      out  dump in progress
//   done      out  one-cycle pulse after the final word handshake
//   rf_addr   out  register-file read address
//   rf_data   in   register-file read data (updated on the falling edge)
//   out_valid out  out_data/out_idx valid
//   out_ready in   downstream accepts the word
//   out_data  out  dumped word
//   out_idx   out  index of out_data (NUM_REGS for the checksum word)
// -----------------------------------------------------------------------------
module reg_dump
   import reg_dump_pkg::*;
#(
   parameter int NUM_REGS = DEFAULT_NUM_REGS,
   parameter int ADDR_W   = DEFAULT_ADDR_W,
   parameter int DATA_W   = DEFAULT_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rf_addr,
   input  logic [DATA_W-1:0] rf_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W:0]   out_idx
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
`ifdef REG_DUMP_CHECKSUM_EN
   localparam logic [ADDR_W:0]   SUM_IDX  = (ADDR_W + 1)'(NUM_REGS);
`endif

   state_t            state;
   logic [ADDR_W-1:0] idx;
`ifdef REG_DUMP_CHECKSUM_EN
   logic [DATA_W-1:0] checksum;
`endif

   // Dump sequencer: state, index counter, read address and output holding register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         idx       <= '0;
         rf_addr   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
         checksum  <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               idx  <= '0;
               if (start) begin
                  state   <= ST_FETCH;
                  rf_addr <= '0;
                  busy    <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                  checksum <= '0;
`endif
               end
            end

            // rf_addr was set at the edge opening this cycle; the register
            // file latched the word on the falling edge, so it is safe here.
            ST_FETCH: begin
               out_data  <= rf_data;
               out_idx   <= {1'b0, idx};
               out_valid <= 1'b1;
               state     <= ST_SEND;
`ifdef REG_DUMP_CHECKSUM_EN
               checksum  <= checksum ^ rf_data;
`endif
            end

            ST_SEND: begin
               if (out_ready) begin
                  if (idx == LAST_IDX) begin
`ifdef REG_DUMP_CHECKSUM_EN
                     // out_valid stays high: the checksum word follows directly
                     state    <= ST_SUM;
                     out_data <= checksum;
                     out_idx  <= SUM_IDX;
`else
                     state     <= ST_FIN;
                     out_valid <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
`endif
                  end else begin
                     idx       <= idx + ADDR_W'(1);
                     rf_addr   <= idx + ADDR_W'(1);
                     out_valid <= 1'b0;
                     state     <= ST_FETCH;
                  end
               end
            end

`ifdef REG_DUMP_CHECKSUM_EN
            ST_SUM: begin
               if (out_ready) begin
                  state     <= ST_FIN;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
               end
            end
`endif

            // done is high for exactly this one cycle; a start seen here is dropped
            ST_FIN: begin
               done  <= 1'b0;
               idx   <= '0;
               state <= ST_IDLE;
            end

            default: begin
               state     <= ST_IDLE;
               idx       <= '0;
               busy      <= 1'b0;
               done      <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_dump.sv
// -----------------------------------------------------------------------------
// tb_reg_dump
// Directed bench for reg_dump with a behavioural register file whose read
// port updates on the falling clock edge. Define REG_DUMP_CHECKSUM_EN for
// both RTL and bench to exercise the checksum word.
// -----------------------------------------------------------------------------
module tb_reg_dump;

   localparam int NR = 32;
`ifdef REG_DUMP_CHECKSUM_EN
   localparam int NW  = NR + 1;
   localparam int LAT = 2 * NR + 2;
`else
   localparam int NW  = NR;
   localparam int LAT = 2 * NR + 1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        busy;
   logic        done;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [5:0]  out_idx;

   logic [31:0] regs    [NR];
   logic [31:0] exp_mem [NR];
   logic [31:0] got_data[NW + 4];
   logic [5:0]  got_idx [NW + 4];

   int ncmp = 0;
   int nerr = 0;
   int words;
   int dones;
   int lat;

   reg_dump dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .rf_addr  (rf_addr),
      .rf_data  (rf_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_idx  (out_idx)
   );

   always #5 clk = ~clk;

   // Register-file read port: data registered on the falling edge
   always @(negedge clk) rf_data <= regs[rf_addr];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load_pattern();
      for (int i = 0; i < NR; i++) begin
         regs[i]    = (i == 0) ? 32'd0 : (32'd1 << i);
         exp_mem[i] = regs[i];
      end
   endtask

   task automatic load_zero();
      for (int i = 0; i < NR; i++) begin
         regs[i]    = 32'd0;
         exp_mem[i] = 32'd0;
      end
   endtask

   // Runs one dump. mode 0: ready always high; mode 1: ready 1 cycle in 4.
   // rs_a/rs_b: re-pulse start after that many handshakes; st_done: pulse
   // start in the done cycle; wb_at: write x5 after that many handshakes.
   task automatic dump(input int mode, input int rs_a, input int rs_b,
                       input bit st_done, input int wb_at);
      int          cyc;
      bit          wait_prev;
      logic [31:0] hd;
      logic [5:0]  hi;
      words = 0; dones = 0; lat = 0; wait_prev = 1'b0; hd = 32'd0; hi = 6'd0;
      out_ready = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      chk("busy_after_start", 64'(busy), 64'd1);
      while (dones == 0 && cyc < 1000) begin
         if (wait_prev) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'(out_data), 64'(hd));
            chk("hold_idx", 64'(out_idx), 64'(hi));
         end
         if (done) begin
            dones++;
            lat = cyc;
            chk("busy_at_done", 64'(busy), 64'd0);
            if (st_done) start = 1'b1;
         end
         out_ready = (mode == 0) || (cyc % 4 == 0);
         if (out_valid && out_ready && words < NW + 4) begin
            got_data[words] = out_data;
            got_idx[words]  = out_idx;
            words++;
            if (words == rs_a || words == rs_b) start = 1'b1;
            if (words == wb_at) regs[5] = 32'hDEADBEEF;
         end
         wait_prev = out_valid && !out_ready;
         hd = out_data;
         hi = out_idx;
         @(posedge clk); #1;
         start = 1'b0;
         cyc++;
      end
      out_ready = 1'b0;
      chk("done_seen", 64'(dones), 64'd1);
      chk("word_count", 64'(words), 64'(NW));
      if (mode == 0) chk("latency", 64'(lat), 64'(LAT));
      // No second done pulse and no restart from an ignored start
      for (int k = 0; k < 8; k++) begin
         chk("post_done", 64'(done), 64'd0);
         chk("post_valid", 64'(out_valid), 64'd0);
         chk("post_busy", 64'(busy), 64'd0);
         @(posedge clk); #1;
      end
   endtask

   task automatic check_words(input string tag);
      logic [31:0] x;
      x = 32'd0;
      for (int i = 0; i < NR; i++) x = x ^ exp_mem[i];
      for (int i = 0; i < NW && i < words; i++) begin
         chk({tag, "_data"}, 64'(got_data[i]), 64'((i < NR) ? exp_mem[i] : x));
         chk({tag, "_idx"}, 64'(got_idx[i]), 64'(i));
      end
   endtask

   initial begin
      int guard;
      for (int i = 0; i < NR; i++) regs[i] = 32'd0;

      // Reset state
      #12;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_addr", 64'(rf_addr), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_idx", 64'(out_idx), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // Pattern dump, ready tied high
      load_pattern();
      dump(0, -1, -1, 1'b0, -1);
      check_words("pat");
      chk("pat_w1", 64'(got_data[1]), 64'h2);
      chk("pat_w31", 64'(got_data[31]), 64'h8000_0000);
`ifdef REG_DUMP_CHECKSUM_EN
      chk("pat_sum", 64'(got_data[32]), 64'hFFFF_FFFE);
      chk("pat_sum_idx", 64'(got_idx[32]), 64'd32);
`endif

      // Same pattern with back-pressure; start during done is ignored
      dump(1, -1, -1, 1'b1, -1);
      check_words("bp");

      // Zero register file, start re-pulsed while busy
      load_zero();
      dump(0, 5, 20, 1'b0, -1);
      check_words("zero");

      // Reset while word 10 is presented
      load_pattern();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      out_ready = 1'b1;
      guard = 0;
      while (!(out_valid && out_idx == 6'd10) && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("abort_reach_w10", 64'(out_valid && out_idx == 6'd10), 64'd1);
      out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_valid", 64'(out_valid), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_addr", 64'(rf_addr), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      @(posedge clk); #1;
      chk("abort_done2", 64'(done), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      dump(0, -1, -1, 1'b0, -1);
      check_words("after_rst");

      // Writeback to x5 lands before the dump reaches it
      load_pattern();
      exp_mem[5] = 32'hDEADBEEF;
      dump(0, -1, -1, 1'b0, 2);
      check_words("wb");
      chk("wb_w5", 64'(got_data[5]), 64'hDEAD_BEEF);
      chk("wb_w4", 64'(got_data[4]), 64'h10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
